pps_phase_det: RTL and testbench

PPS_PHASE_DET -- requirements
Module: pps_phase_det

---
 rtl/gpsdo_pkg.sv | 13 +
 rtl/pps_edge_sync.sv | 52 +++++
 rtl/pps_phase_det.sv | 123 ++++++++++++
 tb/tb_pps_phase_det.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/gpsdo_pkg.sv
// Shared constants and types for the GPSDO phase-measurement path.
package gpsdo_pkg;

   localparam int CLK_FREQ = 10_000_000;
   localparam int PHASE_W  = 25;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_LOC = 2'd1,
      WAIT_GPS = 2'd2
   } det_state_t;

endpackage

// File: rtl/pps_edge_sync.sv
// Two-stage input pipeline plus rising-edge detector. SYNC=1 marks the stages
// as a metastability synchronizer; SYNC=0 is a plain delay with equal latency.
module pps_edge_sync #(
   parameter bit SYNC = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pps,
   output logic rise
);

   logic [1:0] stg;
   logic       last;
   logic [1:0] prime;
   logic       armed;

   generate
      if (SYNC) begin : g_sync
         (* ASYNC_REG = "TRUE" *) logic [1:0] meta;
         always_ff @(posedge clk) begin
            if (!rst_n) meta <= '0;
            else        meta <= {meta[0], pps};
         end
         assign stg = meta;
      end else begin : g_dly
         logic [1:0] dly;
         always_ff @(posedge clk) begin
            if (!rst_n) dly <= '0;
            else        dly <= {dly[0], pps};
         end
         assign stg = dly;
      end
   endgenerate

   // prime[1] marks stg[1] as holding a real post-reset sample; the detector
   // only arms once that sample is low, so a level held high across reset
   // is not mistaken for a fresh edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last  <= 1'b0;
         prime <= '0;
         armed <= 1'b0;
      end else begin
         last  <= stg[1];
         prime <= {prime[0], 1'b1};
         if (prime[1] && !stg[1]) armed <= 1'b1;
      end
   end

   assign rise = armed && stg[1] && !last;

endmodule

// File: rtl/pps_phase_det.sv
// Measures the signed separation between GPS and local PPS rising edges in
// CLK_SYS cycles, with a measurement window timeout and a GPS-loss flag.
module pps_phase_det import gpsdo_pkg::*; #(
   parameter int WIN_MAX  = 5_000_000,
   parameter int LOST_MAX = 15_000_000
) (
   input  logic               CLK_SYS,
   input  logic               CLK_RST,
   input  logic               _1PPS_GPS,
   input  logic               _1PPS_Local,
   output logic [PHASE_W-1:0] phase_err,
   output logic               err_valid,
   output logic               err_timeout,
   output logic               gps_lost
);

   localparam int CNT_W = PHASE_W - 1;
   localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_MAX - 2);
   localparam logic [23:0]      LOST_TOP = 24'(LOST_MAX);

   logic gps_edge, loc_edge;

   pps_edge_sync #(.SYNC(1'b1)) u_gps (
      .clk   (CLK_SYS),
      .rst_n (CLK_RST),
      .pps   (_1PPS_GPS),
      .rise  (gps_edge)
   );

   pps_edge_sync #(.SYNC(1'b0)) u_loc (
      .clk   (CLK_SYS),
      .rst_n (CLK_RST),
      .pps   (_1PPS_Local),
      .rise  (loc_edge)
   );

   det_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] sep;
   logic             win_end;

   // cnt lags the true separation by one so the register clears on the
   // leaving-IDLE edge; sep is the separation of the current cycle.
   assign sep     = cnt + 1'b1;
   assign win_end = (cnt == WIN_LAST);

   always_ff @(posedge CLK_SYS) begin
      if (!CLK_RST) begin
         state       <= IDLE;
         cnt         <= '0;
         phase_err   <= '0;
         err_valid   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         err_valid   <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (gps_edge && loc_edge) begin
                  phase_err <= '0;
                  err_valid <= 1'b1;
               end else if (gps_edge) begin
                  state <= WAIT_LOC;
                  cnt   <= '0;
               end else if (loc_edge) begin
                  state <= WAIT_GPS;
                  cnt   <= '0;
               end
            end
            WAIT_LOC: begin
               if (loc_edge) begin
                  phase_err <= {1'b0, sep};
                  err_valid <= 1'b1;
                  state     <= IDLE;
               end else if (gps_edge) begin
                  cnt <= '0;
               end else if (win_end) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end else begin
                  cnt <= sep;
               end
            end
            WAIT_GPS: begin
               if (gps_edge) begin
                  phase_err <= -{1'b0, sep};
                  err_valid <= 1'b1;
                  state     <= IDLE;
               end else if (loc_edge) begin
                  cnt <= '0;
               end else if (win_end) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end else begin
                  cnt <= sep;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [23:0] lost_cnt, lost_nxt;

   always_comb begin
      lost_nxt = lost_cnt;
      if (gps_edge)                  lost_nxt = '0;
      else if (lost_cnt != LOST_TOP) lost_nxt = lost_cnt + 1'b1;
   end

   // gps_lost comes out of reset high and stays high until GPS is first seen.
   always_ff @(posedge CLK_SYS) begin
      if (!CLK_RST) begin
         lost_cnt <= '0;
         gps_lost <= 1'b1;
      end else begin
         lost_cnt <= lost_nxt;
         if (gps_edge)                  gps_lost <= 1'b0;
         else if (lost_nxt == LOST_TOP) gps_lost <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pps_phase_det.sv
// Directed bench for pps_phase_det with a shortened window and loss limit.
module tb_pps_phase_det;

   localparam int WIN  = 100;
   localparam int LOST = 300;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        gps = 1'b0;
   logic        loc = 1'b0;
   logic [24:0] phase_err;
   logic        err_valid, err_timeout, gps_lost;

   pps_phase_det #(.WIN_MAX(WIN), .LOST_MAX(LOST)) dut (
      .CLK_SYS     (clk),
      .CLK_RST     (rst_n),
      ._1PPS_GPS   (gps),
      ._1PPS_Local (loc),
      .phase_err   (phase_err),
      .err_valid   (err_valid),
      .err_timeout (err_timeout),
      .gps_lost    (gps_lost)
   );

   always #50 clk = ~clk;

   int cyc = 0;
   int n_valid = 0, n_to = 0, n_both = 0;
   int valid_cyc = -1, to_cyc = -1;
   int total = 0, bad = 0;

   // cyc is the index of the cycle whose outputs are being recorded
   always @(posedge clk) begin
      if (err_valid) begin n_valid++; valid_cyc = cyc; end
      if (err_timeout) begin n_to++; to_cyc = cyc; end
      if (err_valid && err_timeout) n_both++;
      cyc++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   function automatic int perr();
      return int'($signed(phase_err));
   endfunction

   // pulse each input high for 5 cycles starting at offset g / l (-1 = none)
   task automatic drive(input int g, input int l, input int span, output int base);
      base = 0;
      for (int k = 0; k < span; k++) begin
         @(negedge clk);
         if (k == 0) base = cyc;
         gps = (g >= 0 && k >= g && k < g + 5);
         loc = (l >= 0 && k >= l && k < l + 5);
      end
   endtask

   typedef struct {
      string name;
      int    g;
      int    l;
      int    ev;
      int    et;
      int    err;
      int    lat;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int base, v0, t0, n;

      vecs[0] = '{"gps_leads",   0,  25, 1, 0,  25,  28};
      vecs[1] = '{"loc_leads",  40,   0, 1, 0, -40,  43};
      vecs[2] = '{"gps_timeout", 0,  -1, 0, 1, -40, 102};
      vecs[3] = '{"same_cycle",  0,   0, 1, 0,   0,   3};
      vecs[4] = '{"win_edge_p",  0,  99, 1, 0,  99, 102};
      vecs[5] = '{"win_edge_n", 99,   0, 1, 0, -99, 102};
      vecs[6] = '{"loc_timeout",-1,   0, 0, 1, -99, 102};
      vecs[7] = '{"sep_one",     0,   1, 1, 0,   1,   4};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_phase_err", perr(), 0);
      chk("rst_err_valid", int'(err_valid), 0);
      chk("rst_err_timeout", int'(err_timeout), 0);
      chk("rst_gps_lost", int'(gps_lost), 1);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // first GPS edge clears gps_lost, then LOST cycles of silence set it
      @(negedge clk); gps = 1'b1; n = cyc;
      wait_to(n + 2); chk("lost_hold_before_edge", int'(gps_lost), 1);
      wait_to(n + 3); chk("lost_clear_after_edge", int'(gps_lost), 0);
      wait_to(n + 5); gps = 1'b0;
      wait_to(n + 2 + LOST); chk("lost_not_yet", int'(gps_lost), 0);
      wait_to(n + 3 + LOST); chk("lost_set", int'(gps_lost), 1);
      wait_to(n + 20 + LOST); chk("lost_saturated", int'(gps_lost), 1);
      gps = 1'b1; n = cyc;
      wait_to(n + 2); chk("lost_still_set", int'(gps_lost), 1);
      wait_to(n + 3); chk("lost_reclear", int'(gps_lost), 0);
      wait_to(n + 5); gps = 1'b0;
      wait_to(n + 120);

      // table of edge pairs
      for (int i = 0; i < 8; i++) begin
         v0 = n_valid; t0 = n_to;
         drive(vecs[i].g, vecs[i].l, 130, base);
         chk({vecs[i].name, "_valid_cnt"}, n_valid - v0, vecs[i].ev);
         chk({vecs[i].name, "_timeout_cnt"}, n_to - t0, vecs[i].et);
         chk({vecs[i].name, "_phase_err"}, perr(), vecs[i].err);
         if (vecs[i].ev != 0) chk({vecs[i].name, "_valid_cyc"}, valid_cyc - base, vecs[i].lat);
         else                 chk({vecs[i].name, "_timeout_cyc"}, to_cyc - base, vecs[i].lat);
      end

      // repeated GPS edge restarts the measurement
      v0 = n_valid; t0 = n_to;
      for (int k = 0; k < 130; k++) begin
         @(negedge clk);
         if (k == 0) base = cyc;
         gps = (k < 5) || (k >= 10 && k < 15);
         loc = (k >= 30 && k < 35);
      end
      chk("restart_valid_cnt", n_valid - v0, 1);
      chk("restart_timeout_cnt", n_to - t0, 0);
      chk("restart_phase_err", perr(), 20);
      chk("restart_valid_cyc", valid_cyc - base, 33);

      // one-cycle reset while waiting for the local edge
      v0 = n_valid; t0 = n_to;
      @(negedge clk); gps = 1'b1; n = cyc;
      wait_to(n + 5);  gps = 1'b0;
      wait_to(n + 20); rst_n = 1'b0;
      wait_to(n + 21); rst_n = 1'b1;
      wait_to(n + 140);
      chk("midrst_valid_cnt", n_valid - v0, 0);
      chk("midrst_timeout_cnt", n_to - t0, 0);
      chk("midrst_phase_err", perr(), 0);
      chk("midrst_gps_lost", int'(gps_lost), 1);
      v0 = n_valid;
      drive(0, 10, 130, base);
      chk("post_rst_valid_cnt", n_valid - v0, 1);
      chk("post_rst_phase_err", perr(), 10);
      chk("post_rst_valid_cyc", valid_cyc - base, 13);

      // GPS held high through reset must not count as an edge
      @(negedge clk); rst_n = 1'b0; gps = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      v0 = n_valid; t0 = n_to;
      for (int k = 0; k < 130; k++) begin
         @(negedge clk);
         if (k == 0) base = cyc;
         gps = (k < 3) || (k >= 20 && k < 25);
         loc = (k < 5);
      end
      chk("held_high_valid_cnt", n_valid - v0, 1);
      chk("held_high_timeout_cnt", n_to - t0, 0);
      chk("held_high_phase_err", perr(), -20);
      chk("held_high_valid_cyc", valid_cyc - base, 23);

      chk("valid_timeout_overlap", n_both, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
